// File: rtl/uart_pkg.sv
// Shared definitions for the UART pixel receiver: FSM state encoding and
// the default baud / frame-size constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // 50 MHz system clock / 115200 baud
    localparam int BAUD_CNT_MAX_DEF = 434;
    // 180 x 180 gray image
    localparam int PIXEL_TOTAL_DEF  = 32400;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge
// detector on the synchronized signal.
module rx_sync_edge (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic       rx_s1_q, rx_s1_d;
    logic       rx_s2_q, rx_s2_d;
    logic       rx_s3_q, rx_s3_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;

    // Next-state: shift the line through the sync chain. The flops preset to
    // idle-high, so a line that is low when reset releases would otherwise look
    // like a start edge; edges are only accepted once a real high level has
    // been seen after reset (fill_q[1] marks rx_s2_q as holding a real sample).
    always_comb begin
        rx_s1_d = rx;
        rx_s2_d = rx_s1_q;
        rx_s3_d = rx_s2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & rx_s2_q);
    end

    // Register the sync chain with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            rx_s1_q <= rx_s1_d;
            rx_s2_q <= rx_s2_d;
            rx_s3_q <= rx_s3_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
        end
    end

    assign rx_sync = rx_s2_q;
    assign rx_fall = armed_q & rx_s3_q & ~rx_s2_q;

endmodule

// File: rtl/uart_pixel_rx.sv
// UART 8N1 receiver producing one gray pixel per valid byte, with pixel
// counting for frame boundaries and stop-bit error reporting.
//
// state | meaning
// IDLE  | line idle, waiting for a synchronized falling edge
// START | timing the start bit, confirm it is still low at mid-bit
// DATA  | sampling 8 data bits LSB first at mid-bit
// STOP  | checking the stop bit at mid-bit; on error wait for line high
module uart_pixel_rx
    import uart_pkg::*;
#(
    parameter int baud_cnt_max = BAUD_CNT_MAX_DEF,
    parameter int pixel_total  = PIXEL_TOTAL_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       out_flag,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int              BCW       = $clog2(baud_cnt_max);
    localparam logic [BCW-1:0]  BAUD_LAST = BCW'(baud_cnt_max - 1);
    localparam logic [BCW-1:0]  BAUD_MID  = BCW'(baud_cnt_max / 2);
    localparam logic [14:0]     PIX_LAST  = 15'(pixel_total - 1);

    logic            rx_sync;
    logic            rx_fall;

    uart_state_e     state_q, state_d;
    logic [BCW-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            out_flag_q, out_flag_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_err_q, frame_err_d;
    logic [14:0]     pixel_cnt_q, pixel_cnt_d;
    logic            err_wait_q, err_wait_d;
    logic            sample;

    rx_sync_edge u_rx_sync_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .rx_sync   (rx_sync),
        .rx_fall   (rx_fall)
    );

    assign sample = (baud_cnt_q == BAUD_MID);

    // Next-state and output logic. Returning to IDLE at the mid-stop sample
    // leaves half a bit to catch a back-to-back start edge.
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = (baud_cnt_q == BAUD_LAST) ? '0 : baud_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        out_flag_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        pixel_cnt_d  = pixel_cnt_q;
        err_wait_d   = err_wait_q;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                err_wait_d = 1'b0;
                if (rx_fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample) begin
                    if (!rx_sync) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d   = {rx_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (err_wait_q) begin
                    if (rx_sync) begin
                        state_d = IDLE;
                    end
                end else if (sample) begin
                    if (rx_sync) begin
                        data_out_d = shift_q;
                        out_flag_d = 1'b1;
                        state_d    = IDLE;
                        if (pixel_cnt_q == PIX_LAST) begin
                            pixel_cnt_d  = 15'd0;
                            frame_done_d = 1'b1;
                        end else begin
                            pixel_cnt_d = pixel_cnt_q + 15'd1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        err_wait_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            data_out_q   <= 8'd0;
            out_flag_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            pixel_cnt_q  <= 15'd0;
            err_wait_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            out_flag_q   <= out_flag_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            pixel_cnt_q  <= pixel_cnt_d;
            err_wait_q   <= err_wait_d;
        end
    end

    assign data_out   = data_out_q;
    assign out_flag   = out_flag_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_pixel_rx.sv
// Bench for uart_pixel_rx: two instances share one rx line (full-size and
// 4-pixel frames). A byte-level scoreboard predicts every output each cycle.
module tb_uart_pixel_rx;
    import uart_pkg::*;

    localparam int BAUD = 52;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx        = 1'b1;
    logic [7:0] data_out_a, data_out_b;
    logic       out_flag_a, out_flag_b;
    logic       frame_done_a, frame_done_b;
    logic       frame_err_a, frame_err_b;

    uart_pixel_rx #(.baud_cnt_max(BAUD), .pixel_total(32400)) dut_a (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx         (rx),
        .data_out   (data_out_a),
        .out_flag   (out_flag_a),
        .frame_done (frame_done_a),
        .frame_err  (frame_err_a)
    );

    uart_pixel_rx #(.baud_cnt_max(BAUD), .pixel_total(4)) dut_b (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx         (rx),
        .data_out   (data_out_b),
        .out_flag   (out_flag_b),
        .frame_done (frame_done_b),
        .frame_err  (frame_err_b)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state; index 0 = dut_a, 1 = dut_b
    int         pt [2] = '{32400, 4};
    logic [7:0] exp_mem [2][64];
    int         wr_p [2] = '{0, 0};
    int         rd_p [2] = '{0, 0};
    int         err_sent [2] = '{0, 0};
    int         err_seen [2] = '{0, 0};
    int         err_hits [2] = '{0, 0};
    logic [7:0] last_b [2] = '{8'h00, 8'h00};
    int         pix [2] = '{0, 0};
    int         outs [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    int         done_idx [2] = '{0, 0};
    int         flag_cyc [2] = '{0, 0};
    logic [7:0] obs_a [$];

    // Per-cycle compare against the byte-level model
    always begin
        logic [7:0] d_out [2];
        logic       o_flag [2];
        logic       f_done [2];
        logic       f_err [2];
        logic [7:0] eb;
        @(posedge sys_clk);
        #1;
        d_out[0] = data_out_a;  d_out[1] = data_out_b;
        o_flag[0] = out_flag_a; o_flag[1] = out_flag_b;
        f_done[0] = frame_done_a; f_done[1] = frame_done_b;
        f_err[0] = frame_err_a; f_err[1] = frame_err_b;
        for (int k = 0; k < 2; k++) begin
            if (!sys_rst_n) begin
                rd_p[k]     = wr_p[k];
                err_seen[k] = err_sent[k];
                last_b[k]   = 8'h00;
                pix[k]      = 0;
                outs[k]     = 0;
                done_cnt[k] = 0;
                done_idx[k] = 0;
            end else begin
                if (o_flag[k]) begin
                    check("out_flag_expected", int'(rd_p[k] != wr_p[k]), 1);
                    if (rd_p[k] != wr_p[k]) begin
                        eb = exp_mem[k][rd_p[k] % 64];
                        rd_p[k]++;
                        check("frame_done_at_out", int'(f_done[k]), int'(pix[k] == pt[k] - 1));
                        last_b[k] = eb;
                        pix[k] = (pix[k] + 1) % pt[k];
                    end
                    outs[k]++;
                    flag_cyc[k] = cyc;
                    if (f_done[k]) begin
                        done_cnt[k]++;
                        done_idx[k] = outs[k];
                    end
                    if (k == 0) obs_a.push_back(d_out[0]);
                end else begin
                    check("frame_done_idle", int'(f_done[k]), 0);
                end
                check("data_out", int'(d_out[k]), int'(last_b[k]));
                if (f_err[k]) begin
                    check("frame_err_expected", int'(err_seen[k] < err_sent[k]), 1);
                    err_seen[k]++;
                    err_hits[k]++;
                end
            end
        end
    end

    int start_cyc;

    task automatic push_exp(input logic [7:0] b);
        for (int k = 0; k < 2; k++) begin
            exp_mem[k][wr_p[k] % 64] = b;
            wr_p[k]++;
        end
    endtask

    // Called and returns on a negedge; idle_bits = 0 gives back-to-back frames
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int idle_bits);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (BAUD) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge sys_clk);
        end
        if (stop_ok) push_exp(b);
        else begin
            err_sent[0]++;
            err_sent[1]++;
        end
        rx = stop_ok;
        repeat (BAUD) @(negedge sys_clk);
        rx = 1'b1;
        repeat (idle_bits * BAUD) @(negedge sys_clk);
    endtask

    initial begin
        int n0;
        logic [7:0] b81;
        logic [7:0] burst [5];
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        b81 = 8'h81;

        repeat (3) @(negedge sys_clk);
        check("rst_data_out", int'(data_out_a), 0);
        check("rst_out_flag", int'(out_flag_a), 0);
        check("rst_frame_done", int'(frame_done_a), 0);
        check("rst_frame_err", int'(frame_err_a), 0);
        check("rst_pixel_cnt", int'(dut_a.pixel_cnt_q), 0);
        check("rst_state", int'(dut_a.state_q), int'(IDLE));
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // single good byte
        send_byte(8'hA5, 1'b1, 2);
        check("a5_data", int'(data_out_a), 32'hA5);
        check("a5_count", outs[0], 1);
        check("a5_latency", int'((flag_cyc[0] - start_cyc) >= 496 && (flag_cyc[0] - start_cyc) <= 500), 1);
        check("a5_no_err", err_hits[0], 0);

        // short low glitch on idle line
        rx = 1'b0;
        repeat (10) @(negedge sys_clk);
        rx = 1'b1;
        repeat (3 * BAUD) @(negedge sys_clk);
        check("glitch_no_out", outs[0], 1);
        check("glitch_no_err", err_hits[0], 0);
        check("glitch_idle", int'(dut_a.state_q), int'(IDLE));

        // stop bit error
        send_byte(8'h3C, 1'b0, 2);
        check("err_once", err_hits[0], 1);
        check("err_no_out", outs[0], 1);
        check("err_data_kept", int'(data_out_a), 32'hA5);
        check("err_pixel_kept", int'(dut_a.pixel_cnt_q), 1);
        check("err_idle", int'(dut_a.state_q), int'(IDLE));

        // back-to-back bytes
        n0 = obs_a.size();
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h55, 1'b1, 2);
        check("b2b_count", obs_a.size() - n0, 3);
        if (obs_a.size() - n0 == 3) begin
            check("b2b_0", int'(obs_a[n0]), 32'h00);
            check("b2b_1", int'(obs_a[n0 + 1]), 32'hFF);
            check("b2b_2", int'(obs_a[n0 + 2]), 32'h55);
        end

        // frame boundary with 4-pixel frames
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        for (int i = 0; i < 5; i++) send_byte(burst[i], 1'b1, (i == 4) ? 2 : 0);
        check("frame_done_count", done_cnt[1], 1);
        check("frame_done_index", done_idx[1], 4);
        check("pixel_wrap_b", int'(dut_b.pixel_cnt_q), 1);
        check("pixel_cnt_a", int'(dut_a.pixel_cnt_q), 5);
        check("no_frame_done_a", done_cnt[0], 0);

        // reset during bit 4 of 0x81, then 0x7E
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        rx = 1'b0;
        repeat (BAUD) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            rx = b81[i];
            repeat (BAUD) @(negedge sys_clk);
        end
        rx = b81[4];
        repeat (26) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (BAUD - 28) @(negedge sys_clk);
        for (int i = 5; i < 8; i++) begin
            rx = b81[i];
            repeat (BAUD) @(negedge sys_clk);
        end
        rx = 1'b1;
        repeat (3 * BAUD) @(negedge sys_clk);
        check("rst_mid_no_out", outs[0], 0);
        send_byte(8'h7E, 1'b1, 2);
        check("after_rst_count", outs[0], 1);
        check("after_rst_data", int'(data_out_a), 32'h7E);
        check("after_rst_data_b", int'(data_out_b), 32'h7E);

        repeat (20) @(negedge sys_clk);
        for (int k = 0; k < 2; k++) begin
            check("pending_bytes", wr_p[k] - rd_p[k], 0);
            check("pending_errs", err_sent[k] - err_seen[k], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_pixel_rx.md
UART_PIXEL_RX -- requirements
Module: uart_pixel_rx

Interface
REQ-001 The block SHALL have parameter baud_cnt_max, default 434, giving sys_clk cycles per UART bit (50 MHz / 115200); simulation overrides it to 52.
REQ-002 The block SHALL have parameter pixel_total, default 32400, giving pixels per frame (180 x 180).
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port sys_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous UART line, idle high.
REQ-006 The block SHALL have port data_out, output, 8 bits: last valid received byte (gray pixel), feeding the Sobel stage data_in.
REQ-007 The block SHALL have port out_flag, output, 1 bit: one-cycle strobe, data_out valid, feeding the Sobel stage in_flag.
REQ-008 The block SHALL have port frame_done, output, 1 bit: one-cycle strobe on the last pixel of a frame.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle strobe on a stop-bit error.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use; a start is detected on a synchronized falling edge while in IDLE.
REQ-011 The FSM SHALL have states IDLE, START, DATA, and STOP.
REQ-012 IDLE -> START on a detected falling edge; baud_cnt is cleared to 0.
REQ-013 baud_cnt SHALL count 0..baud_cnt_max-1 and wrap; the bit sample point is baud_cnt == baud_cnt_max/2 (integer division).
REQ-014 In START at the sample point: if rx is low, go to DATA with bit_cnt = 0; if rx is high (glitch), go to IDLE with no outputs.
REQ-015 In DATA, sample one bit per bit period at the sample point, LSB first, into an 8-bit shift register; after bit 7, go to STOP.
REQ-016 In STOP at the sample point: if rx is high, load data_out, pulse out_flag, and go to IDLE.
REQ-017 In STOP at the sample point: if rx is low, pulse frame_err, leave data_out and pixel_cnt unchanged, and go to IDLE only after the line returns high.
REQ-018 Return to IDLE at the mid-stop sample so that back-to-back bytes with zero idle time are received without loss.
REQ-019 out_flag, frame_done, and frame_err SHALL be registered and asserted in the cycle after the deciding sample; each is high for exactly 1 cycle.
REQ-020 data_out SHALL hold its value until the next valid byte.
REQ-021 pixel_cnt (15 bits) SHALL increment on each out_flag.
REQ-022 When pixel_cnt == pixel_total-1 at out_flag, frame_done SHALL be asserted in the same cycle as out_flag and pixel_cnt SHALL wrap to 0.
REQ-023 Latency from the start-bit falling edge at the synchronizer output to out_flag SHALL be 9*baud_cnt_max + baud_cnt_max/2 + 1 cycles, within ±1 cycle.
REQ-024 A falling edge seen in START, DATA, or STOP SHALL be ignored; only IDLE detects a start.

Reset
REQ-025 When sys_rst_n is low at a sys_clk edge, the FSM SHALL go to IDLE and the following SHALL clear to 0: baud_cnt, bit_cnt, pixel_cnt, shift register, data_out, out_flag, frame_done, frame_err.
REQ-026 When sys_rst_n is low at a sys_clk edge, the synchronizer flops SHALL preset to 1.
REQ-027 A reset asserted mid-byte SHALL discard the partial byte; reception resumes at the next falling edge after reset is released.

Structure
REQ-028 The FSM state encoding and the default baud/pixel constants SHALL live in a shared package, uart_pkg.
REQ-029 The 2-flop synchronizer plus falling-edge detector SHALL be one sub-module, rx_sync_edge; the FSM, counters, and shifter SHALL be in uart_pixel_rx.

Verification (baud_cnt_max = 52, pixel_total = 32400 unless stated)
REQ-030 Send byte 0xA5 with a correct frame -> data_out = 0xA5, out_flag high for 1 cycle about 495 cycles after the start edge, frame_err = 0.
REQ-031 Send a 10-cycle low glitch on an idle line -> no out_flag, no frame_err, FSM back in IDLE.
REQ-032 Send 0x3C with the stop bit driven low -> frame_err pulses once, no out_flag, data_out keeps its previous value, pixel_cnt unchanged.
REQ-033 Send bytes 0x00, 0xFF, 0x55 back-to-back with no idle bits -> three out_flag pulses carrying 0x00, 0xFF, 0x55 in that order.
REQ-034 With pixel_total = 4, send 5 bytes -> frame_done coincides with the 4th out_flag only, and pixel_cnt = 1 after the 5th.
REQ-035 Assert sys_rst_n low for 2 cycles during bit 4 of 0x81, then send 0x7E -> no output for 0x81, then data_out = 0x7E with one out_flag.
